// File: rtl/svd_stream_sequencer.sv
// ============================================================================
// svd_stream_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//    Stream front/back end for a combinational 2x2 SVD datapath. A 4-word
//    single-precision matrix frame (row-major a11,a12,a21,a22) is collected
//    from an AXI-Stream style slave port and presented to the datapath as four
//    stable operand registers. After SETTLE_CYCLES the datapath results
//    (sigma1/2, U, V) are captured into a local buffer and re-emitted as a
//    10-word result frame on an AXI-Stream style master port. Only one matrix
//    is in flight at a time; the slave port backpressures while busy.
//
// Parameters:
//    SETTLE_CYCLES  cycles the operands are held before capture (1..255)
//    CHECK_TLAST    1: input tlast must mark word 3 only; 0: tlast ignored
//
// Ports:
//    aclk               clock, everything on the rising edge
//    reset              synchronous active-high reset
//    s_axis_tdata       input matrix word
//    s_axis_tvalid      input word valid
//    s_axis_tready      input word accepted when valid & ready
//    s_axis_tlast       marks a22 (word 3) of an input frame
//    a11..a22           registered operands to the SVD datapath
//    sigma1, sigma2     singular values from the datapath
//    u11..u22           left singular vectors from the datapath
//    v11..v22           right singular vectors from the datapath
//    m_axis_tdata       result word
//    m_axis_tvalid      result word valid
//    m_axis_tready      downstream accepts when valid & ready
//    m_axis_tlast       high on result word 9 (v22)
//    frame_err          1-cycle pulse on an input framing error
//    busy               high whenever the sequencer is not loading
//    frame_count        completed result frames, wraps at 16 bits
// ============================================================================
module svd_stream_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter bit CHECK_TLAST   = 1'b1
) (
   input  logic        aclk,
   input  logic        reset,

   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,

   output logic [31:0] a11,
   output logic [31:0] a12,
   output logic [31:0] a21,
   output logic [31:0] a22,

   input  logic [31:0] sigma1,
   input  logic [31:0] sigma2,
   input  logic [31:0] u11,
   input  logic [31:0] u12,
   input  logic [31:0] u21,
   input  logic [31:0] u22,
   input  logic [31:0] v11,
   input  logic [31:0] v12,
   input  logic [31:0] v21,
   input  logic [31:0] v22,

   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,

   output logic        frame_err,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
   localparam logic [3:0] LAST_OUT    = 4'd9;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } state_t;

   state_t      state;
   logic [1:0]  in_idx;
   logic [31:0] shadow [4];
   logic [7:0]  settle_cnt;
   logic [31:0] result_buf [10];
   logic [3:0]  out_idx;

   logic        in_fire;
   logic        tlast_early;
   logic        tlast_missing;

   // The slave port is only open while loading, and is forced closed while
   // reset is held so no word can be taken during the reset cycle itself.
   // busy is simply "not loading"; both are direct decodes of the state.
   always_comb begin
      s_axis_tready = (state == LOAD) && !reset;
      busy          = (state != LOAD);
      in_fire       = s_axis_tvalid && s_axis_tready;
      tlast_early   = CHECK_TLAST && s_axis_tlast && (in_idx != 2'd3);
      tlast_missing = CHECK_TLAST && !s_axis_tlast && (in_idx == 2'd3);
   end

   // Main sequencer. Input words 0..3 land in shadow registers so the operand
   // outputs never show a half-loaded matrix; the operands are copied from the
   // shadows on the first SETTLE cycle, so they all change on one edge. The
   // settle counter then gives the combinational float chain time to resolve
   // before the ten results are frozen into result_buf, which decouples the
   // output stream from anything the datapath does afterwards. In SEND the
   // first cycle only loads the output register; after that a word advances
   // strictly on a valid & ready handshake, so tdata/tlast are held steady
   // under backpressure. Shadow and result buffers carry no reset because
   // they are always fully rewritten before being used.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state         <= LOAD;
         in_idx        <= 2'd0;
         settle_cnt    <= 8'd0;
         out_idx       <= 4'd0;
         a11           <= 32'd0;
         a12           <= 32'd0;
         a21           <= 32'd0;
         a22           <= 32'd0;
         m_axis_tdata  <= 32'd0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         frame_err     <= 1'b0;
         frame_count   <= 16'd0;
      end else begin
         frame_err <= 1'b0;

         case (state)
            LOAD: begin
               if (in_fire) begin
                  if (in_idx != 2'd3) begin
                     if (tlast_early) begin
                        // Frame ended too soon: throw the partial words away
                        // and wait for a fresh word 0.
                        in_idx    <= 2'd0;
                        frame_err <= 1'b1;
                     end else begin
                        shadow[in_idx] <= s_axis_tdata;
                        in_idx         <= in_idx + 2'd1;
                     end
                  end else begin
                     // A missing tlast on word 3 is flagged but the matrix is
                     // still complete, so it is processed normally.
                     shadow[3]  <= s_axis_tdata;
                     in_idx     <= 2'd0;
                     frame_err  <= tlast_missing;
                     settle_cnt <= SETTLE_LOAD;
                     state      <= SETTLE;
                  end
               end
            end

            SETTLE: begin
               if (settle_cnt == SETTLE_LOAD) begin
                  a11 <= shadow[0];
                  a12 <= shadow[1];
                  a21 <= shadow[2];
                  a22 <= shadow[3];
               end
               settle_cnt <= settle_cnt - 8'd1;
               if (settle_cnt == 8'd1) begin
                  state <= CAPTURE;
               end
            end

            CAPTURE: begin
               result_buf[0] <= sigma1;
               result_buf[1] <= sigma2;
               result_buf[2] <= u11;
               result_buf[3] <= u12;
               result_buf[4] <= u21;
               result_buf[5] <= u22;
               result_buf[6] <= v11;
               result_buf[7] <= v12;
               result_buf[8] <= v21;
               result_buf[9] <= v22;
               out_idx       <= 4'd0;
               state         <= SEND;
            end

            SEND: begin
               if (!m_axis_tvalid) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= result_buf[out_idx];
                  m_axis_tlast  <= (out_idx == LAST_OUT);
               end else if (m_axis_tready) begin
                  if (out_idx == LAST_OUT) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     frame_count   <= frame_count + 16'd1;
                     state         <= LOAD;
                  end else begin
                     out_idx      <= out_idx + 4'd1;
                     m_axis_tdata <= result_buf[out_idx + 4'd1];
                     m_axis_tlast <= (out_idx == (LAST_OUT - 4'd1));
                  end
               end
            end

            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule
